// File: rtl/line_transfer_unit.sv
// Line transfer engine between the cache data BRAM and the memory-side bus:
// streams a line out for writeback, or writes incoming bus beats in for refill.
module line_transfer_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LINE_WORDS = 16
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        req_valid,
  output logic                                        req_ready,
  input  logic                                        req_is_wb,
  input  logic [ADDR_WIDTH-$clog2(LINE_WORDS)-1:0]    req_line,
  output logic                                        wb_valid,
  input  logic                                        wb_ready,
  output logic [DATA_WIDTH-1:0]                       wb_data,
  output logic                                        wb_last,
  input  logic                                        fill_valid,
  output logic                                        fill_ready,
  input  logic [DATA_WIDTH-1:0]                       fill_data,
  input  logic                                        fill_last,
  output logic                                        bram_en,
  output logic [DATA_WIDTH/8-1:0]                     bram_write_en,
  output logic [ADDR_WIDTH-1:0]                       bram_addr,
  output logic [DATA_WIDTH-1:0]                       bram_data_in,
  input  logic [DATA_WIDTH-1:0]                       bram_data_out,
  output logic                                        done,
  output logic                                        err
);

  localparam int OFFSET_BITS = $clog2(LINE_WORDS);
  localparam int LINE_BITS   = ADDR_WIDTH - OFFSET_BITS;
  localparam int BE_WIDTH    = DATA_WIDTH / 8;
  localparam logic [OFFSET_BITS-1:0] LAST_IDX = OFFSET_BITS'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_ISSUE,
    S_WB_SEND,
    S_FILL,
    S_DONE
  } state_t;

  state_t                  state_q, state_nxt;
  logic [LINE_BITS-1:0]    base_q, base_nxt;
  logic [OFFSET_BITS-1:0]  idx_q, idx_nxt;
  logic                    mismatch_q, mismatch_nxt;
  logic [OFFSET_BITS-1:0]  idx_inc;
  logic                    at_last;

  assign idx_inc = idx_q + OFFSET_BITS'(1);
  assign at_last = (idx_q == LAST_IDX);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; reset is synchronous and only touches control state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      idx_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      base_q     <= base_nxt;
      idx_q      <= idx_nxt;
      mismatch_q <= mismatch_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt     = state_q;
    base_nxt      = base_q;
    idx_nxt       = idx_q;
    mismatch_nxt  = mismatch_q;
    req_ready     = 1'b0;
    wb_valid      = 1'b0;
    wb_data       = '0;
    wb_last       = 1'b0;
    fill_ready    = 1'b0;
    bram_en       = 1'b0;
    bram_write_en = '0;
    bram_addr     = '0;
    bram_data_in  = '0;
    done          = 1'b0;
    err           = 1'b0;

    // Outputs stay quiet for the whole reset cycle so no stray write lands.
    if (!reset) begin
      unique case (state_q)
        S_IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            base_nxt     = req_line;
            idx_nxt      = '0;
            mismatch_nxt = 1'b0;
            state_nxt    = req_is_wb ? S_WB_ISSUE : S_FILL;
          end
        end

        S_WB_ISSUE: begin
          bram_en   = 1'b1;
          bram_addr = {base_q, {OFFSET_BITS{1'b0}}};
          state_nxt = S_WB_SEND;
        end

        S_WB_SEND: begin
          wb_valid  = 1'b1;
          wb_data   = bram_data_out;
          wb_last   = at_last;
          // Prefetch only on a handshake so the BRAM output holds under stall.
          bram_en   = wb_ready && !at_last;
          bram_addr = {base_q, idx_inc};
          if (wb_ready) begin
            idx_nxt = idx_inc;
            if (at_last) state_nxt = S_DONE;
          end
        end

        S_FILL: begin
          fill_ready = 1'b1;
          if (fill_valid) begin
            bram_en       = 1'b1;
            bram_write_en = {BE_WIDTH{1'b1}};
            bram_addr     = {base_q, idx_q};
            bram_data_in  = fill_data;
            idx_nxt       = idx_inc;
            if (fill_last != at_last) mismatch_nxt = 1'b1;
            if (at_last) state_nxt = S_DONE;
          end
        end

        S_DONE: begin
          done      = 1'b1;
          err       = mismatch_q;
          state_nxt = S_IDLE;
        end

        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_transfer_unit.sv
// Self-checking bench for line_transfer_unit: BRAM model, scoreboard queues
// for writeback beats, BRAM writes and line completions.
module tb_line_transfer_unit;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = 16;
  localparam int LB = AW - $clog2(LW);

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_is_wb;
  logic [LB-1:0] req_line;
  logic          wb_valid, wb_ready, wb_last;
  logic [DW-1:0] wb_data;
  logic          fill_valid, fill_ready, fill_last;
  logic [DW-1:0] fill_data;
  logic          bram_en;
  logic [3:0]    bram_write_en;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_data_in, bram_data_out;
  logic          done, err;

  line_transfer_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_WORDS(LW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_wb(req_is_wb), .req_line(req_line),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_last(wb_last),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_data(fill_data), .fill_last(fill_last),
    .bram_en(bram_en), .bram_write_en(bram_write_en), .bram_addr(bram_addr),
    .bram_data_in(bram_data_in), .bram_data_out(bram_data_out),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] data; logic last; } wb_exp_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_exp_t;

  wb_exp_t exp_wb[$];
  wr_exp_t exp_wr[$];
  logic    exp_done[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_req, t_last, t_first_wb, t_done;
  logic wb_seen;
  logic stall_mode = 1'b0;

  // Golden line contents, updated only from stimulus.
  logic [DW-1:0] gold [0:(1<<AW)-1];

  // BRAM model: port A from the DUT (1-cycle read, write-first), port B preload.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pb_we = 1'b0;
  logic [AW-1:0] pb_addr;
  logic [DW-1:0] pb_data;

  always @(posedge clk) begin
    logic [DW-1:0] w;
    cyc <= cyc + 1;
    if (pb_we) mem[pb_addr] <= pb_data;
    if (bram_en) begin
      w = mem[bram_addr];
      for (int b = 0; b < 4; b++)
        if (bram_write_en[b]) w[8*b +: 8] = bram_data_in[8*b +: 8];
      if (bram_write_en != 4'h0) mem[bram_addr] <= w;
      bram_data_out <= w;
    end
  end

  initial forever begin
    @(posedge clk);
    #1 wb_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: all outputs sampled on the falling edge.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  always @(negedge clk) begin
    wb_exp_t ew;
    wr_exp_t er;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (wb_valid) begin
        if (!wb_seen) begin wb_seen = 1'b1; t_first_wb = cyc; end
        if (prev_stall) check("wb_stable", wb_data, prev_data);
        if (wb_ready) begin
          if (exp_wb.size() == 0) check("wb_extra_beat", 1, 0);
          else begin
            ew = exp_wb.pop_front();
            check("wb_data", wb_data, ew.data);
            check("wb_last", wb_last, ew.last);
          end
        end else begin
          check("stall_bram_en", bram_en, 0);
        end
      end
      prev_stall = wb_valid && !wb_ready;
      prev_data  = wb_data;
      if (bram_en && bram_write_en != 4'h0) begin
        check("wr_only_on_beat", fill_valid, 1);
        check("wr_byte_en", bram_write_en, 4'hF);
        if (exp_wr.size() == 0) check("wr_extra", 1, 0);
        else begin
          er = exp_wr.pop_front();
          check("wr_addr", bram_addr, er.addr);
          check("wr_data", bram_data_in, er.data);
        end
      end
      if (done) begin
        t_done = cyc;
        if (exp_done.size() == 0) check("done_extra", 1, 0);
        else check("done_err", err, exp_done.pop_front());
      end
    end
  end

  // All stimulus tasks start and end one time unit after a rising edge.
  task automatic preload(input int line, input logic [DW-1:0] base_val);
    for (int i = 0; i < LW; i++) begin
      pb_we   = 1'b1;
      pb_addr = AW'(line * LW + i);
      pb_data = base_val + DW'(i);
      gold[line * LW + i] = base_val + DW'(i);
      @(posedge clk); #1;
    end
    pb_we = 1'b0;
  endtask

  task automatic do_req(input logic is_wb, input int line);
    bit ok = 0;
    req_valid = 1'b1;
    req_is_wb = is_wb;
    req_line  = LB'(line);
    wb_seen   = 1'b0;
    if (is_wb) begin
      for (int i = 0; i < LW; i++)
        exp_wb.push_back('{data: gold[line * LW + i], last: (i == LW - 1)});
      exp_done.push_back(1'b0);
    end
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) check("req_timeout", 1, 0);
    t_req = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drive_beat(input int line, input int i, input logic [DW-1:0] d, input logic last);
    bit ok = 0;
    fill_valid = 1'b1;
    fill_data  = d;
    fill_last  = last;
    exp_wr.push_back('{addr: AW'(line * LW + i), data: d});
    gold[line * LW + i] = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (fill_ready) begin ok = 1; break; end
    end
    if (!ok) check("fill_timeout", 1, 0);
    t_last = cyc;
    @(posedge clk); #1;
    fill_valid = 1'b0;
    fill_last  = 1'b0;
    fill_data  = 32'hBAD0_BAD0;
  endtask

  task automatic fill_line(input int line, input logic [DW-1:0] base_val, input int last_pos,
                           input bit gaps);
    for (int i = 0; i < LW; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      if (i == LW - 1) exp_done.push_back(last_pos != LW - 1);
      drive_beat(line, i, base_val + DW'(i), i == last_pos);
    end
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (exp_done.size() == 0 && exp_wb.size() == 0 && exp_wr.size() == 0) begin ok = 1; break; end
    end
    if (!ok) check("done_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_is_wb = 1'b0; req_line = '0;
    fill_valid = 1'b0; fill_last = 1'b0; fill_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);
    check("idle_outputs", {wb_valid, fill_ready, bram_en, done, err}, 0);
    @(posedge clk); #1;

    // 1: writeback, no backpressure
    preload(3, 32'h1000);
    do_req(1'b1, 3);
    wait_done();
    check("wb_first_latency", t_first_wb - t_req, 2);
    check("wb_done_latency", t_done - t_req, 18);

    // 2: writeback with random stalls
    preload(4, 32'h2000);
    stall_mode = 1'b1;
    do_req(1'b1, 4);
    wait_done();
    stall_mode = 1'b0;

    // 3: refill with fill_valid gaps
    do_req(1'b0, 5);
    fill_line(5, 32'hA0, 15, 1'b1);
    wait_done();
    for (int i = 0; i < LW; i++) check("fill_mem", mem[80 + i], 32'hA0 + i);

    // 4: fill_last early, then never
    do_req(1'b0, 6);
    fill_line(6, 32'hB0, 7, 1'b0);
    wait_done();
    do_req(1'b0, 7);
    fill_line(7, 32'hD0, -1, 1'b1);
    wait_done();

    // 5: reset mid-refill after beat 4
    preload(10, 32'h5500);
    do_req(1'b0, 10);
    for (int i = 0; i < 5; i++) drive_beat(10, i, 32'hE0 + DW'(i), 1'b0);
    reset      = 1'b1;
    fill_valid = 1'b1;
    fill_data  = 32'hDEAD_0005;
    @(negedge clk);
    check("rst_outputs", {req_ready, wb_valid, wb_last, fill_ready, bram_en, bram_write_en,
                          done, err, bram_addr, bram_data_in, wb_data}, 0);
    @(posedge clk); #1;
    fill_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1);
    check("abandoned_word", mem[10 * LW + 5], 32'h5505);
    check("abandoned_written", mem[10 * LW + 4], 32'hE4);
    @(posedge clk); #1;
    do_req(1'b1, 3);
    wait_done();

    // 6: refill then immediate writeback of the same line
    do_req(1'b0, 9);
    fill_line(9, 32'hC0, 15, 1'b0);
    do_req(1'b1, 9);
    check("b2b_gap", t_req - t_last, 2);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
